// File: rtl/risc_pkg.sv
// Shared encodings for the simple-RISC control FSM: states, instruction
// fields, memory command, writeback mux and register-select codes.
package risc_pkg;

  localparam int IR_W = 16;

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_IF1  = 5'd1,
    S_IF2  = 5'd2,
    S_UPC  = 5'd3,
    S_DEC  = 5'd4,
    S_WIMM = 5'd5,
    S_GETA = 5'd6,
    S_GETB = 5'd7,
    S_EXEC = 5'd8,
    S_EXMV = 5'd9,
    S_WRC  = 5'd10,
    S_CMP  = 5'd11,
    S_ADR  = 5'd12,
    S_LADR = 5'd13,
    S_MRD  = 5'd14,
    S_WRM  = 5'd15,
    S_SGB  = 5'd16,
    S_SC   = 5'd17,
    S_SW   = 5'd18,
    S_HALT = 5'd19
  } state_e;

  // Instruction class captured in S_DEC so later shared states can route
  // without looking at the IR again.
  typedef enum logic [2:0] {
    C_MOVR = 3'd0,
    C_MVN  = 3'd1,
    C_ALU  = 3'd2,
    C_CMP  = 3'd3,
    C_LDR  = 3'd4,
    C_STR  = 3'd5
  } cls_e;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RN   = 3'b100;

endpackage

// File: rtl/risc_cpu_fsm.sv
// Moore control FSM for the 16-bit simple-RISC datapath.
//
// state  | meaning
// S_RST  | PC := 0
// S_IF1  | fetch: PC drives address, memory read
// S_IF2  | fetch: IR loads memory data
// S_UPC  | PC := PC + 1
// S_DEC  | decode opcode/op, latch instruction class
// S_WIMM | Rn := sximm8
// S_GETA | A := Rn
// S_GETB | B := Rm
// S_EXEC | C := ALU(A, B)
// S_EXMV | C := ALU(0, B)  (MOV reg)
// S_WRC  | Rd := C
// S_CMP  | status := ALU(A, B)
// S_ADR  | C := A + sximm5
// S_LADR | data address := C
// S_MRD  | memory read at data address
// S_WRM  | Rd := mdata
// S_SGB  | B := Rd
// S_SC   | C := 0 + B
// S_SW   | memory write C at data address
// S_HALT | stopped until reset
module risc_cpu_fsm
  import risc_pkg::*;
#(
  parameter int IR_W = risc_pkg::IR_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [IR_W-1:IR_W-3]    opcode,
  input  logic [IR_W-4:IR_W-5]    op,
  output logic [2:0]              nsel,
  output logic [1:0]              vsel,
  output logic                    write,
  output logic                    loada,
  output logic                    loadb,
  output logic                    loadc,
  output logic                    loads,
  output logic                    asel,
  output logic                    bsel,
  output logic                    load_ir,
  output logic                    load_pc,
  output logic                    reset_pc,
  output logic                    addr_sel,
  output logic                    load_addr,
  output logic [1:0]              mem_cmd,
  output logic                    halted
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;

  // State and instruction-class registers; reset aborts anything in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RST;
      cls_q   <= C_ALU;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next state; the IR fields are only looked at in S_DEC.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      S_RST:  state_d = S_IF1;
      S_IF1:  state_d = S_IF2;
      S_IF2:  state_d = S_UPC;
      S_UPC:  state_d = S_DEC;
      S_DEC: begin
        case ({opcode, op})
          {OPC_MOV, OP_MOV_IMM}: state_d = S_WIMM;
          {OPC_MOV, OP_MOV_REG}: begin state_d = S_GETB; cls_d = C_MOVR; end
          {OPC_ALU, OP_MVN}:     begin state_d = S_GETB; cls_d = C_MVN;  end
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_AND}:     begin state_d = S_GETA; cls_d = C_ALU;  end
          {OPC_ALU, OP_CMP}:     begin state_d = S_GETA; cls_d = C_CMP;  end
          {OPC_LDR, OP_MEM}:     begin state_d = S_GETA; cls_d = C_LDR;  end
          {OPC_STR, OP_MEM}:     begin state_d = S_GETA; cls_d = C_STR;  end
          default:               state_d = S_HALT;
        endcase
      end
      S_GETA: state_d = (cls_q == C_LDR || cls_q == C_STR) ? S_ADR : S_GETB;
      S_GETB: begin
        if (cls_q == C_MOVR)     state_d = S_EXMV;
        else if (cls_q == C_CMP) state_d = S_CMP;
        else                     state_d = S_EXEC;
      end
      S_EXEC, S_EXMV: state_d = S_WRC;
      S_ADR:  state_d = S_LADR;
      S_LADR: state_d = (cls_q == C_LDR) ? S_MRD : S_SGB;
      S_MRD:  state_d = S_WRM;
      S_SGB:  state_d = S_SC;
      S_SC:   state_d = S_SW;
      S_WIMM, S_WRC, S_CMP, S_WRM, S_SW: state_d = S_IF1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Moore output decode: every strobe is a function of the state alone.
  always_comb begin
    nsel      = NSEL_NONE;
    vsel      = VSEL_C;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state_q)
      S_RST:  begin reset_pc = 1'b1; load_pc = 1'b1; end
      S_IF1:  begin addr_sel = 1'b1; mem_cmd = MEM_READ; end
      S_IF2:  begin addr_sel = 1'b1; mem_cmd = MEM_READ; load_ir = 1'b1; end
      S_UPC:  load_pc = 1'b1;
      S_WIMM: begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
      S_GETA: begin nsel = NSEL_RN; loada = 1'b1; end
      S_GETB: begin nsel = NSEL_RM; loadb = 1'b1; end
      S_EXEC: loadc = 1'b1;
      S_EXMV, S_SC: begin asel = 1'b1; loadc = 1'b1; end
      S_WRC:  begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_CMP:  loads = 1'b1;
      S_ADR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LADR: load_addr = 1'b1;
      S_MRD:  mem_cmd = MEM_READ;
      S_WRM:  begin mem_cmd = MEM_READ; nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; end
      S_SGB:  begin nsel = NSEL_RD; loadb = 1'b1; end
      S_SW:   mem_cmd = MEM_WRITE;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
